// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store, memory and halt signals around mem_port_arbiter.
// master: arbiter side; slave: requester/memory environment side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              halt_req;
  logic              halted;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
           mem_rvalid, mem_rdata, halt_req,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata, halted
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
           mem_rvalid, mem_rdata, halt_req,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_size, mem_addr, mem_wdata, halted
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port arbiter between fetch and load/store, with halt drain.
// Define ARB_RR_EN for round-robin on contested requests; default is fixed D-over-IF priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t            state, state_n;
  owner_t            owner, owner_n;
  logic              we_q, we_n;
  logic [2:0]        size_q, size_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              halted_q, halted_n;
  logic              pick_d;
  logic              go;
`ifdef ARB_RR_EN
  owner_t            last_winner, last_winner_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
`ifdef ARB_RR_EN
      last_winner <= OWN_IF;
`endif
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      we_q     <= we_n;
      size_q   <= size_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      halted_q <= halted_n;
`ifdef ARB_RR_EN
      last_winner <= last_winner_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    we_n     = we_q;
    size_n   = size_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    halted_n = (state == IDLE) && bus.halt_req;
    go       = (state == IDLE) && !bus.halt_req && (bus.d_req || bus.if_req);
`ifdef ARB_RR_EN
    // Contested: grant whoever did not win the previous contest.
    pick_d        = bus.d_req && (!bus.if_req || (last_winner == OWN_IF));
    last_winner_n = last_winner;
    if (go && bus.d_req && bus.if_req)
      last_winner_n = pick_d ? OWN_D : OWN_IF;
`else
    pick_d = bus.d_req;
`endif

    unique case (state)
      IDLE: begin
        if (go) begin
          state_n = ISSUE;
          if (pick_d) begin
            owner_n = OWN_D;
            we_n    = bus.d_we;
            size_n  = bus.d_size;
            addr_n  = bus.d_addr;
            wdata_n = bus.d_wdata;
          end else begin
            owner_n = OWN_IF;
            we_n    = 1'b0;
            size_n  = 3'b010;
            addr_n  = bus.if_addr;
          end
        end
      end
      ISSUE: state_n = WAIT;
      WAIT:  if (bus.mem_rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_req   = (state == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_gnt    = (state == ISSUE) && (owner == OWN_IF);
  assign bus.d_gnt     = (state == ISSUE) && (owner == OWN_D);
  assign bus.if_rvalid = (state == WAIT) && bus.mem_rvalid && (owner == OWN_IF);
  assign bus.d_rvalid  = (state == WAIT) && bus.mem_rvalid && (owner == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.halted    = halted_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention order, halt drain, reset, spurious response.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.halt_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %0h exp 0", bus.mem_req); end
    tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %0h exp 0", bus.mem_addr); end
    tests++; if (bus.mem_size !== 3'h0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_size_we got %0h/%0h exp 0/0", bus.mem_size, bus.mem_we); end
    tests++; if (bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_mem_wdata got %0h exp 0", bus.mem_wdata); end
    tests++; if ({bus.if_gnt, bus.d_gnt, bus.halted} !== 3'b000) begin fails++; $display("FAIL reset_gnt_halted got %b exp 000", {bus.if_gnt, bus.d_gnt, bus.halted}); end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_fetch();
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_rdata = 32'hDEADBEEF; #1;
    tests++; if (bus.if_gnt !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL fetch_c0_idle got gnt %0h req %0h exp 0 0", bus.if_gnt, bus.mem_req); end
    @(negedge clk); #1;
    tests++; if (bus.if_gnt !== 1'b1 || bus.mem_req !== 1'b1 || bus.d_gnt !== 1'b0) begin fails++; $display("FAIL fetch_c1_gnt got if %0h req %0h d %0h exp 1 1 0", bus.if_gnt, bus.mem_req, bus.d_gnt); end
    tests++; if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_size !== 3'b010) begin fails++; $display("FAIL fetch_c1_payload got %0h/%0h/%0h exp 100/0/2", bus.mem_addr, bus.mem_we, bus.mem_size); end
    @(negedge clk); bus.mem_rvalid = 1'b1; #1;
    tests++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL fetch_c2_rvalid got %0h data %0h exp 1 deadbeef", bus.if_rvalid, bus.if_rdata); end
    tests++; if (bus.d_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL fetch_c2_other got d_rvalid %0h req %0h exp 0 0", bus.d_rvalid, bus.mem_req); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b0; #1;
    tests++; if (bus.if_gnt !== 1'b0 || bus.if_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_c3_idle got gnt %0h rvalid %0h exp 0 0", bus.if_gnt, bus.if_rvalid); end
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 3'b000; bus.d_addr = 32'h20; bus.d_wdata = 32'hAB; bus.if_addr = 32'h500; #1;
    @(negedge clk); #1;
    tests++; if (bus.d_gnt !== 1'b1 || bus.mem_req !== 1'b1 || bus.if_gnt !== 1'b0) begin fails++; $display("FAIL store_gnt got d %0h req %0h if %0h exp 1 1 0", bus.d_gnt, bus.mem_req, bus.if_gnt); end
    for (int unsigned c = 0; c < 3; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      tests++; if (bus.mem_we !== 1'b1 || bus.mem_size !== 3'b000 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'hAB)
        begin fails++; $display("FAIL store_payload_c%0d got %0h/%0h/%0h/%0h exp 1/0/20/ab", c, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata); end
      tests++; if (bus.d_rvalid !== 1'b0 || (c != 0 && bus.mem_req !== 1'b0)) begin fails++; $display("FAIL store_wait_c%0d got rvalid %0h req %0h exp 0", c, bus.d_rvalid, bus.mem_req); end
    end
    @(negedge clk); bus.mem_rvalid = 1'b1; #1;
    tests++; if (bus.d_rvalid !== 1'b1 || bus.if_rvalid !== 1'b0) begin fails++; $display("FAIL store_ack got d %0h if %0h exp 1 0", bus.d_rvalid, bus.if_rvalid); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; #1;
  endtask

  task automatic test_contention();
    logic [3:0] order;
`ifdef ARB_RR_EN
    order = 4'b0101;
`else
    order = 4'b1111;
`endif
    for (int unsigned t = 0; t < 4; t++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h180; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 3'b010; bus.d_addr = 32'h80;
      bus.mem_rvalid = 1'b0; #1;
      tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL contend_idle_%0d got req %0h exp 0", t, bus.mem_req); end
      @(negedge clk); #1;
      tests++; if (bus.d_gnt !== order[t] || bus.if_gnt !== !order[t] || bus.mem_addr !== (order[t] ? 32'h80 : 32'h180))
        begin fails++; $display("FAIL contend_gnt_%0d got d %0h if %0h addr %0h exp d %0h", t, bus.d_gnt, bus.if_gnt, bus.mem_addr, order[t]); end
      @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1000 + t; #1;
      tests++; if (bus.d_rvalid !== order[t] || bus.if_rvalid !== !order[t])
        begin fails++; $display("FAIL contend_rvalid_%0d got d %0h if %0h exp d %0h", t, bus.d_rvalid, bus.if_rvalid, order[t]); end
    end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0; #1;
  endtask

  task automatic test_halt();
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; #1;
    @(negedge clk); #1;
    tests++; if (bus.d_gnt !== 1'b1) begin fails++; $display("FAIL halt_load_gnt got %0h exp 1", bus.d_gnt); end
    @(negedge clk); bus.halt_req = 1'b1; #1;
    @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234; #1;
    tests++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1234 || bus.halted !== 1'b0)
      begin fails++; $display("FAIL halt_load_ret got rvalid %0h data %0h halted %0h exp 1 1234 0", bus.d_rvalid, bus.d_rdata, bus.halted); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h600; #1;
    tests++; if (bus.halted !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL halt_first_idle got halted %0h req %0h exp 0 0", bus.halted, bus.mem_req); end
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      tests++; if (bus.halted !== 1'b1 || bus.mem_req !== 1'b0 || bus.if_gnt !== 1'b0)
        begin fails++; $display("FAIL halt_hold_%0d got halted %0h req %0h gnt %0h exp 1 0 0", c, bus.halted, bus.mem_req, bus.if_gnt); end
    end
    @(negedge clk); bus.halt_req = 1'b0; #1;
    tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_drop_lag got %0h exp 1", bus.halted); end
    @(negedge clk); #1;
    tests++; if (bus.halted !== 1'b0 || bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h600)
      begin fails++; $display("FAIL halt_resume got halted %0h gnt %0h addr %0h exp 0 1 600", bus.halted, bus.if_gnt, bus.mem_addr); end
    @(negedge clk); bus.mem_rvalid = 1'b1; #1;
    tests++; if (bus.if_rvalid !== 1'b1) begin fails++; $display("FAIL halt_resume_rvalid got %0h exp 1", bus.if_rvalid); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b0; #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h200; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    tests++; if (bus.mem_addr !== 32'h200 || bus.if_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_wait got addr %0h rvalid %0h exp 200 0", bus.mem_addr, bus.if_rvalid); end
    @(negedge clk); rst_n = 1'b0; bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; #1;
    tests++; if (bus.mem_addr !== 32'h0 || bus.mem_size !== 3'h0 || bus.mem_req !== 1'b0 || bus.halted !== 1'b0)
      begin fails++; $display("FAIL rstmid_clear got addr %0h size %0h req %0h halted %0h exp 0", bus.mem_addr, bus.mem_size, bus.mem_req, bus.halted); end
    tests++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid got %0h/%0h exp 0/0", bus.if_rvalid, bus.d_rvalid); end
    @(negedge clk); rst_n = 1'b1; #1;
    @(negedge clk); #1;
    tests++; if (bus.if_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin fails++; $display("FAIL rstmid_late got rvalid %0h req %0h exp 0 0", bus.if_rvalid, bus.mem_req); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h300; #1;
    @(negedge clk); #1;
    tests++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h300) begin fails++; $display("FAIL rstmid_regrant got gnt %0h addr %0h exp 1 300", bus.if_gnt, bus.mem_addr); end
    @(negedge clk); bus.mem_rvalid = 1'b1; #1;
    tests++; if (bus.if_rvalid !== 1'b1) begin fails++; $display("FAIL rstmid_rvalid2 got %0h exp 1", bus.if_rvalid); end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b0; #1;
  endtask

  task automatic test_spurious();
    for (int unsigned c = 0; c < 2; c++) begin
      @(negedge clk); bus.mem_rvalid = 1'b1; #1;
      tests++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.mem_req !== 1'b0)
        begin fails++; $display("FAIL spurious_%0d got if %0h d %0h req %0h exp 0 0 0", c, bus.if_rvalid, bus.d_rvalid, bus.mem_req); end
    end
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h700; #1;
    @(negedge clk); #1;
    tests++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h700) begin fails++; $display("FAIL spurious_still_idle got gnt %0h addr %0h exp 1 700", bus.if_gnt, bus.mem_addr); end
    @(negedge clk); bus.mem_rvalid = 1'b1; #1;
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.if_req = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_halt();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester and the load/store requester, with one outstanding transaction at a time. Sits between the fetch/memory stages and the unified memory model. Arbitrates, latches the winning request, drives the memory port and routes the response back to the owner. Also provides a halt drain so the halt from the decoder completes cleanly.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetch response data
- d_req  in  1  load/store request, level
- d_we  in  1  1 = store
- d_size  in  3  funct3 size/sign code, passed through
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  load data / store ack valid
- d_rdata  out  DATA_W  load data
- mem_req  out  1  one-cycle request pulse to memory
- mem_we, mem_size, mem_addr, mem_wdata  out  1/3/ADDR_W/DATA_W  latched payload
- mem_rvalid  in  1  memory response (load data or store ack), ≥1 cycle after mem_req
- mem_rdata  in  DATA_W  memory read data
- halt_req  in  1  stop issuing new transactions
- halted  out  1  no transaction outstanding and none will issue

## Operation
- States: IDLE, ISSUE, WAIT. Owner register: IF or D.
- IDLE: if halt_req=1, no arbitration. Else if d_req or if_req, pick a winner (see Configuration), latch payload (fetch: mem_we=0, mem_size=3'b010, wdata unchanged), set owner, go to ISSUE.
- ISSUE (1 cycle): mem_req=1, owner's gnt=1. Go to WAIT.
- WAIT: hold payload. On mem_rvalid=1: owner's rvalid=1 combinationally in the same cycle, rdata=mem_rdata; go to IDLE.
- if_rdata/d_rdata always equal mem_rdata; only rvalid is qualified by owner.
- Requesters hold req and payload stable through and including their rvalid cycle. They may change req/payload in the next cycle, which is when IDLE samples again.
- mem_rvalid in IDLE or ISSUE is ignored: no rvalid to anyone.
- halted is registered: 1 in the cycle after an IDLE cycle with halt_req=1, and held while halt_req=1 and in IDLE. Deasserting halt_req clears halted next cycle and resumes arbitration.

## Timing
- Reset values: state IDLE, owner IF, mem_req 0, mem_we 0, mem_size 0, mem_addr 0, mem_wdata 0, if_gnt 0, d_gnt 0, halted 0, last_winner IF.
- Request sampled in IDLE at cycle N, then gnt and mem_req at N+1, then earliest rvalid at N+2.
- Next sample is at rvalid+1. Minimum 3 cycles per transaction.
- halt_req asserted during ISSUE/WAIT: the transaction completes normally, IDLE performs no arbitration, and halted=1 the following cycle.
- Reset asserted mid-transaction: all state clears immediately (asynchronous). The transaction is dropped, and a late mem_rvalid is ignored.

## Configuration
- ARB_RR_EN defined: if both requesters are active in IDLE, grant to the requester that is not last_winner. last_winner updates only on contested arbitrations and resets to IF, so D wins the first contest. Uncontested requests are granted directly.
- ARB_RR_EN undefined: fixed priority, d_req always beats if_req. last_winner is absent.

## Test plan
- Reset, then if_req=1, if_addr=0x100, memory latency 1, mem_rdata=0xDEADBEEF. Required: if_gnt and mem_req at cycle 1 with mem_addr=0x100, mem_we=0; if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 2; d_rvalid=0.
- Store: d_req=1, d_we=1, d_size=3'b000, d_addr=0x20, d_wdata=0xAB, latency 3. Required: mem_req pulse with matching payload held stable for 3 cycles; d_rvalid on ack; no if_rvalid.
- if_req and d_req both high and held for 4 transactions. Without ARB_RR_EN: the order is D,D,D,D. With ARB_RR_EN: the order is D,IF,D,IF.
- halt_req raised during WAIT of a load. Required: d_rvalid still delivered, no further mem_req while if_req=1, halted=1 one cycle after return to IDLE. Dropping halt_req resumes fetch.
- rst_n pulsed low during WAIT, then a late mem_rvalid=1. Required: all outputs at reset values, no rvalid, and the next if_req is granted normally.
- Spurious mem_rvalid while IDLE. Required: no if_rvalid/d_rvalid and the state stays IDLE.
